trng_conditioner: RTL
=====================

# trng_conditioner

Parametrised post-processing stage for the ring-oscillator entropy source. It takes one sampled raw bit per valid strobe and runs a repetition-count health test on the raw stream. The bits then pass through a selectable conditioner: raw, von Neumann debias, von Neumann XOR LFSR, or LFSR only. The block packs the result into WORD_W-bit words and presents them on a valid/ready output with a one-word holding buffer. It sits between the sampled oscillator XOR output and any consumer (display, key register, host readout).

## Interface
- WORD_W, 8: output word width; legal 4..32.
- LFSR_W, 16: LFSR length; legal 16 (taps 16,15,13,4) or 32 (taps 32,22,2,1), Fibonacci, shift toward MSB, feedback into bit 0.
- REP_LIMIT, 8: raw run length that trips the health test; legal 2..63.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable; low freezes LFSR, pair phase and assembler.
- mode  in  2  0 = raw, 1 = von Neumann, 2 = von Neumann XOR lfsr[0], 3 = lfsr[0] per accepted bit (debug).
- raw_bit  in  1  entropy bit, already synchronous to clk.
- raw_valid  in  1  raw_bit is valid this cycle.
- clear_fail  in  1  clears health_fail, overrun, run counter, pair phase, and any partial word.
- word_data  out  WORD_W  conditioned word; first bit collected is the MSB.
- word_valid  out  1  word_data holds an unread word.
- word_ready  in  1  consumer accepts word this cycle.
- health_fail  out  1  sticky flag: repetition test tripped.
- overrun  out  1  sticky flag: a completed word was dropped because the buffer was full.

## Operation
- Accepted bit: enable & raw_valid & !clear_fail & !health_fail.
- Repetition test on every accepted raw bit, before conditioning:
  - run counter is reset to 1 on a bit different from the previous one; otherwise it increments.
  - When run reaches REP_LIMIT, health_fail sets. The tripping bit is discarded and not conditioned.
  - The first bit after reset or clear starts run = 1.
- Von Neumann (modes 1 and 2): the pair phase toggles on each accepted bit.
  - Phase 0 stores the bit.
  - Phase 1 compares with the stored bit. If the two differ, the first bit of the pair is emitted; otherwise nothing is emitted.
- Mode 0 emits every accepted bit.
- Mode 3 emits lfsr[0] for every accepted bit.
- Mode 2 emits vn_bit ^ lfsr[0], sampled in the same cycle.
- LFSR: advances every cycle while enable = 1, independent of raw_valid. Reset seed is 1.
- Assembler: each emitted bit shifts in at the LSB and a bit counter runs 0..WORD_W-1. On the WORD_W-th bit the word completes and the counter returns to 0.
- Completed word handling:
  - If the buffer is empty, or is being read this cycle (word_valid & word_ready), the word loads into word_data and word_valid rises.
  - Otherwise the word is discarded and overrun sets.
- Mode change (mode differs from its registered copy): pair phase and assembler counter clear. The holding buffer is untouched.
- While health_fail = 1, no bits are accepted. A word already in the buffer remains readable.
- clear_fail has priority over everything: a raw bit arriving in the same cycle is dropped. The LFSR and holding buffer are unaffected.

## Timing
- Reset values: word_data = 0, word_valid = 0, health_fail = 0, overrun = 0, LFSR = 1, run = 0, pair phase = 0, assembler count = 0, registered mode = 0.
- Latency from the accepted bit that completes a word to word_valid = 1 is one clock (registered).
- health_fail and overrun assert one clock after the triggering edge.
- Handshake:
  - word_valid stays high and word_data stays stable until a cycle with word_ready = 1.
  - word_valid drops the following cycle unless a new word loads in that same cycle. That gives back-to-back throughput of one word per WORD_W emitted bits.
- Reset asserted mid-word discards all state immediately (asynchronous). Outputs are at reset values before the next clock edge.
- Bits accepted per cycle: at most one. In von Neumann modes, at most one bit is emitted per two accepted bits.

## Test plan
- Reset behaviour: pulse rst_n low mid-operation with word_valid = 1 -> all outputs read 0 asynchronously; the LFSR restarts from 1.
- Raw packing: mode 0, WORD_W = 8, word_ready = 1, feed 1,0,1,1,0,0,1,0 on consecutive cycles -> word_data = 8'hB2, word_valid high exactly one cycle after the 8th bit.
- Von Neumann: mode 1, feed the pairs 01, 10, 00, 11 repeated four times -> emitted bits 0,1 per group, giving word_data = 8'h55.
- Health test: REP_LIMIT = 8, feed eight consecutive 1s -> health_fail = 1 after the 8th bit and no word produced. Assert clear_fail for one cycle -> flag clears and the next 8 alternating bits produce a word.
- Backpressure:
  - Hold word_ready = 0 and feed 16 bits in mode 0 -> the first word is held, the second is dropped, overrun = 1.
  - Then raise word_ready -> the first word is read and word_valid falls.
- Mode switch and LFSR: switch from mode 0 to 3 after 5 bits -> the partial word is discarded. The next 8 accepted bits equal the LFSR bit-0 sequence from a golden model seeded at 1.

Source files
------------

// File: rtl/trng_conditioner.sv
// Entropy post-processing: repetition-count health test, selectable conditioner
// (raw / von Neumann / von Neumann ^ LFSR / LFSR), word packing and a one-word output buffer.
module trng_conditioner #(
   parameter int WORD_W    = 8,
   parameter int LFSR_W    = 16,
   parameter int REP_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic              raw_bit,
   input  logic              raw_valid,
   input  logic              clear_fail,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              health_fail,
   output logic              overrun
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam int RUN_W = 6;
   localparam logic [31:0] TAPS = (LFSR_W == 32) ? 32'h8020_0003 : 32'h0000_D008;

   logic [LFSR_W-1:0] lfsr_reg;
   logic [RUN_W-1:0]  run_reg;
   logic              prev_bit_reg;
   logic              phase_reg;
   logic              vn_first_reg;
   logic [1:0]        mode_reg;
   logic [WORD_W-1:0] shift_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic              lfsr_fb;
   logic              accept;
   logic              mode_chg;
   logic [RUN_W-1:0]  run_next;
   logic              trip;
   logic              cond;
   logic              vn_mode;
   logic              phase_cur;
   logic [CNT_W-1:0]  cnt_cur;
   logic              vn_pair;
   logic              emit;
   logic              emit_bit;
   logic [WORD_W-1:0] shift_next;
   logic              complete;
   logic              buf_read;

   assign lfsr_fb  = ^(lfsr_reg & TAPS[LFSR_W-1:0]);
   assign accept   = enable & raw_valid & ~clear_fail & ~health_fail;
   assign mode_chg = enable & (mode != mode_reg);
   assign run_next = ((run_reg != '0) && (raw_bit == prev_bit_reg)) ? run_reg + RUN_W'(1) : RUN_W'(1);
   assign trip     = accept & (run_next == RUN_W'(REP_LIMIT));
   // The bit that trips the health test never reaches the conditioner.
   assign cond     = accept & ~trip;
   assign vn_mode  = mode[1] ^ mode[0];

   // A mode change behaves as if pair phase and bit count were already zero this cycle.
   assign phase_cur = mode_chg ? 1'b0 : phase_reg;
   assign cnt_cur   = mode_chg ? '0 : cnt_reg;
   assign vn_pair   = cond & phase_cur & (raw_bit != vn_first_reg);

   always_comb begin
      emit     = 1'b0;
      emit_bit = 1'b0;
      case (mode)
         2'd0: begin
            emit     = cond;
            emit_bit = raw_bit;
         end
         2'd1: begin
            emit     = vn_pair;
            emit_bit = vn_first_reg;
         end
         2'd2: begin
            emit     = vn_pair;
            emit_bit = vn_first_reg ^ lfsr_reg[0];
         end
         default: begin
            emit     = cond;
            emit_bit = lfsr_reg[0];
         end
      endcase
   end

   assign shift_next = {shift_reg[WORD_W-2:0], emit_bit};
   assign complete   = emit & (cnt_cur == CNT_W'(WORD_W - 1));
   assign buf_read   = word_valid & word_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_reg     <= LFSR_W'(1);
         run_reg      <= '0;
         prev_bit_reg <= 1'b0;
         phase_reg    <= 1'b0;
         vn_first_reg <= 1'b0;
         mode_reg     <= 2'd0;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         word_data    <= '0;
         word_valid   <= 1'b0;
         health_fail  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (enable) begin
            lfsr_reg <= {lfsr_reg[LFSR_W-2:0], lfsr_fb};
            mode_reg <= mode;
         end

         if (clear_fail) begin
            health_fail <= 1'b0;
            overrun     <= 1'b0;
            run_reg     <= '0;
            phase_reg   <= 1'b0;
            cnt_reg     <= '0;
         end else begin
            if (accept) begin
               run_reg      <= run_next;
               prev_bit_reg <= raw_bit;
            end
            if (trip)
               health_fail <= 1'b1;
            if (mode_chg) begin
               phase_reg <= 1'b0;
               cnt_reg   <= '0;
            end
            if (cond && vn_mode) begin
               phase_reg <= ~phase_cur;
               if (!phase_cur)
                  vn_first_reg <= raw_bit;
            end
            if (emit) begin
               shift_reg <= shift_next;
               cnt_reg   <= complete ? '0 : cnt_cur + CNT_W'(1);
            end
            if (complete && word_valid && !word_ready)
               overrun <= 1'b1;
         end

         if (complete && (!word_valid || word_ready)) begin
            word_data  <= shift_next;
            word_valid <= 1'b1;
         end else if (buf_read) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule
